// File: rtl/fpu_arbiter_pkg.sv
// Shared definitions for the Fixed_Point_Unit arbiter: FPU operation codes,
// arbiter state encodings and requester ID width.
package fpu_arbiter_pkg;

    typedef enum logic [1:0] {
        FPU_ADD  = 2'b00,
        FPU_SUB  = 2'b01,
        FPU_MUL  = 2'b10,
        FPU_SQRT = 2'b11
    } fpu_op_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_EXEC = 2'b01,
        ARB_RESP = 2'b10
    } arb_state_e;

    localparam int unsigned NUM_REQ  = 2;
    localparam int unsigned REQ_ID_W = 1;

    // MUL and SQRT run on FPU sequencers and report completion through ready.
    function automatic logic is_multicycle(input fpu_op_e op);
        return (op == FPU_MUL) || (op == FPU_SQRT);
    endfunction

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Two-way round-robin grant: when both requesters are valid the pointer picks
// the winner, otherwise the single valid requester wins.
module fpu_rr_arbiter
    import fpu_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0]  i_valid,
    input  logic                i_ptr,
    output logic [NUM_REQ-1:0]  o_grant,
    output logic [REQ_ID_W-1:0] o_grant_id
);

    logic w_any;

    assign w_any      = |i_valid;
    assign o_grant_id = (&i_valid) ? i_ptr : i_valid[1];
    assign o_grant    = {o_grant_id, ~o_grant_id} & {NUM_REQ{w_any}};

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one Fixed_Point_Unit between two requesters: grants round-robin, holds
// the FPU inputs for the whole operation and returns the tagged result.
module fpu_arbiter
    import fpu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned GUARD_CYCLES   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [3:0]           req_operation,
    input  logic [2*WIDTH-1:0]   req_operand_1,
    input  logic [2*WIDTH-1:0]   req_operand_2,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [WIDTH-1:0]     rsp_result,
    output logic                 rsp_error,
    output logic [1:0]           fpu_operation,
    output logic [WIDTH-1:0]     fpu_operand_1,
    output logic [WIDTH-1:0]     fpu_operand_2,
    input  logic [WIDTH-1:0]     fpu_result,
    input  logic                 fpu_ready,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic             r_rr_ptr;
    logic [CNT_W-1:0] r_cnt;
    fpu_op_e          r_op;
    logic [WIDTH-1:0] r_operand_1;
    logic [WIDTH-1:0] r_operand_2;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_error;

    logic [1:0]       w_grant;
    logic             w_grant_id;
    logic             w_accept;
    logic             w_capture;
    logic             w_timeout;

    fpu_rr_arbiter u_rr (
        .i_valid    (req_valid),
        .i_ptr      (r_rr_ptr),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id)
    );

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        req_ready   = '0;
        case (r_state)
            ARB_IDLE: begin
                if (!reset) begin
                    req_ready = w_grant;
                    w_accept  = |w_grant;
                end
                if (w_accept) w_state_nxt = ARB_EXEC;
            end
            ARB_EXEC: begin
                // The MUL ready level from the previous multiply lingers into the first issue cycles.
                if (is_multicycle(r_op)) w_capture = (r_cnt >= CNT_W'(GUARD_CYCLES)) && fpu_ready;
                else                     w_capture = (r_cnt == '0);
                w_timeout = !w_capture && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
                if (w_capture || w_timeout) w_state_nxt = ARB_RESP;
            end
            ARB_RESP: begin
                if (rsp_ready) w_state_nxt = ARB_IDLE;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ARB_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr     <= 1'b0;
            r_cnt        <= '0;
            r_op         <= FPU_ADD;
            r_operand_1  <= '0;
            r_operand_2  <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_error  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op        <= fpu_op_e'(w_grant_id ? req_operation[3:2] : req_operation[1:0]);
                r_operand_1 <= w_grant_id ? req_operand_1[2*WIDTH-1:WIDTH] : req_operand_1[WIDTH-1:0];
                r_operand_2 <= w_grant_id ? req_operand_2[2*WIDTH-1:WIDTH] : req_operand_2[WIDTH-1:0];
                r_rsp_id    <= w_grant_id;
                r_rr_ptr    <= ~w_grant_id;
                r_cnt       <= '0;
            end else if (r_state == ARB_EXEC) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_capture) begin
                r_rsp_result <= fpu_result;
                r_rsp_error  <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_result <= '0;
                r_rsp_error  <= 1'b1;
            end
        end
    end

    // ADD outside EXEC keeps the FPU sequencers from being re-triggered.
    assign fpu_operation = (r_state == ARB_EXEC) ? r_op : FPU_ADD;
    assign fpu_operand_1 = r_operand_1;
    assign fpu_operand_2 = r_operand_2;
    assign rsp_valid     = (r_state == ARB_RESP);
    assign rsp_id        = r_rsp_id;
    assign rsp_result    = r_rsp_result;
    assign rsp_error     = r_rsp_error;
    assign busy          = (r_state != ARB_IDLE);

    for (genvar gi = 0; gi < 2; gi++) begin : g_hold_chk
        a_valid_held: assert property (@(posedge clk) disable iff (reset)
            (req_valid[gi] && !req_ready[gi]) |=> req_valid[gi]);
    end

endmodule
